// File: rtl/rr_priority_encoder_if.sv
// Request/grant bus of rr_priority_encoder.
//
// Handshake: the encoder raises valid when idx carries a granted requester.
// A transfer happens on a rising edge where valid && ready. While valid is
// high and ready is low, valid and idx hold unchanged. ready seen while
// valid is low is ignored.
//
// Signals:
//   req   - N request lines, bit i set = requester i wants service
//   mode  - 0 = fixed priority (highest index wins), 1 = round-robin
//   ready - consumer takes idx this cycle
//   valid - idx holds a granted request
//   idx   - encoded index of the granted requester
//   count - accepted transfers, modulo 2^CW
//
// master: the side driving requests and ready (bench / consumer).
// slave : the encoder.
interface rr_priority_encoder_if #(
    parameter int N  = 8,
    parameter int CW = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0]  req;
    logic          mode;
    logic          ready;
    logic          valid;
    logic [W-1:0]  idx;
    logic [CW-1:0] count;

    modport master (output req, mode, ready, input valid, idx, count);
    modport slave  (input req, mode, ready, output valid, idx, count);
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder with fixed and round-robin modes,
// a valid/ready output handshake and an accepted-grant counter.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - rr_priority_encoder_if slave (req, mode, ready in;
//           valid, idx, count out)
//
// The output register reloads whenever it is empty or its content is being
// accepted; otherwise it stalls. Every output is a flop, so there is no
// combinational path from req or mode to valid/idx/count.
module rr_priority_encoder #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rr_priority_encoder_if.slave  bus
);
    localparam int W = $clog2(N);

    logic [W-1:0] ptr;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] fixed_idx;
    logic [W-1:0] rr_low;
    logic [W-1:0] rr_high;
    logic [W-1:0] next_idx;
    logic         rr_hit;
    logic         accept;
    logic         load;
    logic         any_req;

    assign accept  = bus.valid && bus.ready;
    assign load    = !bus.valid || accept;
    assign any_req = |bus.req;

    // Search start for round-robin. On accept it moves one past the grant
    // being taken this cycle, so the same requester cannot win twice in a
    // row while others wait. Wrap is at N-1, so N need not be a power of two.
    always_comb begin
        ptr_eff = ptr;
        if (accept) begin
            if (bus.idx == W'(N - 1)) begin
                ptr_eff = '0;
            end else begin
                ptr_eff = bus.idx + W'(1);
            end
        end
    end

    // fixed_idx: highest set bit (last hit of an upward scan).
    // rr_low   : lowest set bit overall (wrap-around winner).
    // rr_high  : lowest set bit at or above ptr_eff (downward scan, so the
    //            last qualifying hit is the lowest one).
    always_comb begin
        fixed_idx = '0;
        rr_low    = '0;
        rr_high   = '0;
        rr_hit    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bus.req[i]) begin
                fixed_idx = W'(i);
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                rr_low = W'(i);
                if (i >= int'(ptr_eff)) begin
                    rr_high = W'(i);
                    rr_hit  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_idx = '0;
        if (any_req) begin
            if (bus.mode) begin
                next_idx = rr_hit ? rr_high : rr_low;
            end else begin
                next_idx = fixed_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid <= 1'b0;
            bus.idx   <= '0;
            bus.count <= '0;
            ptr       <= '0;
        end else begin
            ptr <= ptr_eff;
            if (accept) begin
                bus.count <= bus.count + CW'(1);
            end
            if (load) begin
                bus.valid <= any_req;
                bus.idx   <= next_idx;
            end
        end
    end
endmodule

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder. Two instances run side by
// side: N=8/CW=8 and N=5/CW=4. A behavioural model predicts both every cycle;
// directed sections also check hand-derived constants and expected index
// sequences held in exp_q.
module tb_rr_priority_encoder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_priority_encoder_if #(.N(8), .CW(8)) b8 ();
    rr_priority_encoder_if #(.N(5), .CW(4)) b5 ();

    rr_priority_encoder #(.N(8), .CW(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    rr_priority_encoder #(.N(5), .CW(4)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

    // ---------------- reference model ----------------
    typedef struct {
        int valid;
        int idx;
        int count;
        int ptr;
    } mstate_t;

    mstate_t m8, m5;

    // Next state from the rules: rotate the search start through 0..n-1
    // in round-robin, or take the highest set bit in fixed mode.
    function automatic mstate_t model_next(mstate_t s, int n, int cw, int req,
                                           int mode, int ready);
        mstate_t r;
        int acc;
        int pe;
        int k;
        bit found;
        r   = s;
        acc = (s.valid != 0 && ready != 0) ? 1 : 0;
        pe  = acc ? (s.idx + 1) % n : s.ptr;
        r.ptr = pe;
        if (acc) r.count = (s.count + 1) % (1 << cw);
        if (s.valid == 0 || acc) begin
            if (req == 0) begin
                r.valid = 0;
                r.idx   = 0;
            end else begin
                r.valid = 1;
                found   = 1'b0;
                if (mode != 0) begin
                    for (int off = 0; off < n; off++) begin
                        k = (pe + off) % n;
                        if (!found && ((req >> k) & 1) == 1) begin
                            r.idx = k;
                            found = 1'b1;
                        end
                    end
                end else begin
                    for (int j = n - 1; j >= 0; j--) begin
                        if (!found && ((req >> j) & 1) == 1) begin
                            r.idx = j;
                            found = 1'b1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("valid8", 32'(b8.valid), m8.valid);
        check("idx8",   32'(b8.idx),   m8.idx);
        check("count8", 32'(b8.count), m8.count);
        check("valid5", 32'(b5.valid), m5.valid);
        check("idx5",   32'(b5.idx),   m5.idx);
        check("count5", 32'(b5.count), m5.count);
        check("idx5_range", 32'(b5.idx < 3'd5), 1);
    endtask

    // ---------------- driver tasks ----------------
    // One clock: predict from the inputs in place before the edge, then
    // compare 1 time unit after the edge.
    task automatic step();
        mstate_t n8, n5;
        n8 = model_next(m8, 8, 8, int'(b8.req), int'(b8.mode), int'(b8.ready));
        n5 = model_next(m5, 5, 4, int'(b5.req), int'(b5.mode), int'(b5.ready));
        @(posedge clk);
        #1;
        m8 = n8;
        m5 = n5;
        check_all();
    endtask

    task automatic drive8(input logic [7:0] req, input logic mode, input logic ready);
        b8.req   = req;
        b8.mode  = mode;
        b8.ready = ready;
    endtask

    task automatic drive5(input logic [4:0] req, input logic mode, input logic ready);
        b5.req   = req;
        b5.mode  = mode;
        b5.ready = ready;
    endtask

    // Assert reset between edges, check outputs cleared at once, release
    // away from the next edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m8 = '{0, 0, 0, 0};
        m5 = '{0, 0, 0, 0};
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_exp_q8(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check(tag, 32'(b8.idx), 32'(e));
        end
    endtask

    task automatic run_exp_q5(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            check(tag, 32'(b5.idx), 32'(e));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive8(8'h00, 1'b0, 1'b0);
        drive5(5'h00, 1'b0, 1'b0);
        m8 = '{0, 0, 0, 0};
        m5 = '{0, 0, 0, 0};
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fixed priority: highest set bit wins, one-cycle latency.
        drive8(8'b0010_0110, 1'b0, 1'b1);
        step();
        check("fixed_idx5", 32'(b8.idx), 5);
        drive8(8'h00, 1'b0, 1'b1);
        step();
        check("fixed_empty_valid", 32'(b8.valid), 0);
        check("fixed_empty_count", 32'(b8.count), 1);

        // Stall: load idx 5, then hold through req/mode changes.
        drive8(8'b0010_0110, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive8(8'h80, i[0] ? 1'b0 : 1'b1, 1'b0);
            step();
            check("stall_idx", 32'(b8.idx), 5);
            check("stall_count", 32'(b8.count), 1);
        end
        drive8(8'h80, 1'b0, 1'b1);
        step();
        check("stall_release_idx", 32'(b8.idx), 7);
        check("stall_release_count", 32'(b8.count), 2);

        // Reach valid=1, idx=5, count=3 stalled, then reset mid-cycle.
        drive8(8'b0010_0110, 1'b0, 1'b1);
        step();
        drive8(8'b0010_0110, 1'b0, 1'b0);
        step();
        check("pre_reset_count", 32'(b8.count), 3);
        drive8(8'h00, 1'b0, 1'b0);
        pulse_reset();
        check("reset_idx_now", 32'(b8.idx), 0);
        step();
        step();
        check("post_reset_valid", 32'(b8.valid), 0);

        // Round-robin sweep from reset with all requests set.
        drive8(8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'd0);
        run_exp_q8("rr_sweep_idx");
        check("rr_sweep_count", 32'(b8.count), 8);

        // Fairness between requesters 0 and 7, then fixed mode.
        drive8(8'h00, 1'b0, 1'b0);
        pulse_reset();
        drive8(8'b1000_0001, 1'b1, 1'b1);
        exp_q = '{8'd0, 8'd7, 8'd0, 8'd7};
        run_exp_q8("rr_fair_idx");
        drive8(8'b1000_0001, 1'b0, 1'b1);
        exp_q = '{8'd7, 8'd7, 8'd7, 8'd7};
        run_exp_q8("fixed_same_idx");

        // N=5, CW=4: alternate 0/4 and wrap the counter after 16 accepts.
        drive8(8'h00, 1'b0, 1'b0);
        pulse_reset();
        drive5(5'b10001, 1'b1, 1'b1);
        exp_q = '{8'd0, 8'd4, 8'd0, 8'd4};
        run_exp_q5("n5_rr_idx");
        for (int i = 0; i < 12; i++) step();
        check("n5_count_15", 32'(b5.count), 15);
        step();
        check("n5_count_wrap", 32'(b5.count), 0);

        // Randomized traffic on both instances with a mid-run reset.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] r8;
            logic [4:0] r5;
            r8 = 8'($urandom);
            r5 = 5'($urandom);
            if ($urandom_range(0, 3) == 0) r8 = r8 & 8'($urandom);
            if ($urandom_range(0, 3) == 0) r5 = r5 & 5'($urandom);
            if ($urandom_range(0, 9) == 0) r8 = 8'h00;
            drive8(r8, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            drive5(r5, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            if (i == 300) pulse_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
